// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames on i_rx to parallel bytes, mid-bit sampling, glitch-start
// rejection, framing-error report and line-break wait. UART_RX_PARITY_EN selects 8E1.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_byte_rdy,
  output logic       o_rx_frame_err,
  output logic       o_rx_parity_err,
  output logic       o_rx_busy
);

  localparam logic [13:0] BIT_LAST = 14'(CLKS_PER_BIT - 1);
  localparam logic [13:0] HALF     = 14'((CLKS_PER_BIT - 1) >> 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_DONE,
    S_BREAK
  } state_t;

  state_t      state_q, state_d;
  logic        rx_meta_q, rx_s_q;
  logic [13:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic        rdy_q, rdy_d;
  logic        ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic        par_q, par_d;
  logic        perr_q, perr_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 14'd1;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    rdy_d   = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        // Recheck at mid start bit; a line already back high was a glitch
        if (cnt_q == HALF) state_d = rx_s_q ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          shift_d[idx_q] = rx_s_q;
          cnt_d          = '0;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          par_d   = rx_s_q;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          byte_d = shift_q;
          if (rx_s_q) begin
            rdy_d   = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = (^shift_q) != par_q;
`endif
            state_d = S_DONE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      S_BREAK: begin
        // Line held low past the stop bit: ignore it until it returns high
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      rdy_q     <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      rdy_q     <= rdy_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign o_rx_byte      = byte_q;
  assign o_rx_byte_rdy  = rdy_q;
  assign o_rx_frame_err = ferr_q;
  assign o_rx_busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign o_rx_parity_err = perr_q;
`else
  assign o_rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are pushed as expectations when driven and
// checked against rdy/frame-error pulses as they appear.
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int NB     = 11;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int NB     = 10;
`endif
  localparam int LAT = 2 + ((CPB - 1) >> 1) + 9 * CPB + 2 + (PAR_EN ? CPB : 0);

  typedef struct packed {
    logic       rdy;
    logic       ferr;
    logic       perr;
    logic [7:0] b;
  } exp_t;

  logic       clk, rst_n, rx;
  logic [7:0] rx_byte;
  logic       rdy, ferr, perr, busy;

  exp_t sb[$];
  int   rdy_cyc[$];
  int   cyc, last_fall;
  int   n_tests, n_fail;
  bit   post_chk, post_rdy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_rx           (rx),
    .o_rx_byte      (rx_byte),
    .o_rx_byte_rdy  (rdy),
    .o_rx_frame_err (ferr),
    .o_rx_parity_err(perr),
    .o_rx_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic stop, input logic par);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
    f[9]   = PAR_EN ? par : stop;
    f[10]  = PAR_EN ? stop : 1'b1;
    return f;
  endfunction

  // Caller is aligned to posedge+1; each bit is held for CPB cycles
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      if (i == 0) last_fall = cyc;
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par);
    exp_t e;
    e.rdy  = stop;
    e.ferr = ~stop;
    e.perr = PAR_EN && stop && ((^b) != par);
    e.b    = b;
    sb.push_back(e);
    send_bits(mk_frame(b, stop, par), NB);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (post_chk) begin
      chk("pulse_1cyc", 32'({rdy, ferr}), 32'd0);
      if (post_rdy) chk("busy_after_done", 32'(busy), 32'd0);
      post_chk = 1'b0;
      post_rdy = 1'b0;
    end
    if (perr && !rdy) chk("perr_orphan", 32'(perr), 32'd0);
    if (rdy || ferr) begin
      chk("rdy_ferr_excl", 32'(rdy & ferr), 32'd0);
      if (sb.size() == 0) begin
        chk("unexp_pulse", 32'({rdy, ferr}), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", 32'({rdy, ferr}), 32'({e.rdy, e.ferr}));
        chk("rx_byte", 32'(rx_byte), 32'(e.b));
        chk("parity_err", 32'(perr), 32'(e.perr));
      end
      if (rdy) rdy_cyc.push_back(cyc);
      post_chk = 1'b1;
      post_rdy = rdy;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n0, gap, lat;
    n_tests  = 0;
    n_fail   = 0;
    post_chk = 1'b0;
    post_rdy = 1'b0;
    last_fall = 0;
    rst_n = 1'b0;
    rx    = 1'b1;
    idle(3);
    chk("rst_byte", 32'(rx_byte), 32'd0);
    chk("rst_rdy",  32'(rdy),     32'd0);
    chk("rst_ferr", 32'(ferr),    32'd0);
    chk("rst_perr", 32'(perr),    32'd0);
    chk("rst_busy", 32'(busy),    32'd0);
    rst_n = 1'b1;
    idle(4);

    // Basic frame and latency from the falling edge
    n0 = rdy_cyc.size();
    send_frame(8'hA5, 1'b1, ^8'hA5);
    idle(4);
    if (rdy_cyc.size() > n0) begin
      lat = rdy_cyc[n0] - last_fall;
      chk("latency_ok", 32'(lat >= LAT - 1 && lat <= LAT + 1), 32'd1);
    end else begin
      chk("latency_seen", 32'(rdy_cyc.size() - n0), 32'd1);
    end

    // Short low glitch must be rejected
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(40);
    chk("glitch_byte", 32'(rx_byte), 32'hA5);
    chk("glitch_busy", 32'(busy), 32'd0);

    // Framing error, then line break of 100 cycles, then a good frame
    send_frame(8'h3C, 1'b0, ^8'h3C);
    idle(50);
    chk("break_busy", 32'(busy), 32'd1);
    chk("break_byte", 32'(rx_byte), 32'h3C);
    idle(34);
    rx = 1'b1;
    idle(32);
    send_frame(8'h81, 1'b1, ^8'h81);
    idle(8);

    // Back-to-back frames with no idle gap
    n0 = rdy_cyc.size();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(8);
    if (rdy_cyc.size() >= n0 + 2) begin
      gap = rdy_cyc[n0 + 1] - rdy_cyc[n0];
      chk("b2b_gap_ok", 32'(gap >= NB * CPB - 1 && gap <= NB * CPB + 1), 32'd1);
    end else begin
      chk("b2b_seen", 32'(rdy_cyc.size() - n0), 32'd2);
    end

    // Reset during data bit 4 abandons the frame
    send_bits(mk_frame(8'h55, 1'b1, 1'b0), 5);
    idle(8);
    rst_n = 1'b0;
    #1;
    chk("abort_byte", 32'(rx_byte), 32'd0);
    chk("abort_rdy",  32'(rdy),     32'd0);
    chk("abort_ferr", 32'(ferr),    32'd0);
    chk("abort_perr", 32'(perr),    32'd0);
    chk("abort_busy", 32'(busy),    32'd0);
    rx = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(20);
    chk("post_rst_busy", 32'(busy), 32'd0);
    send_frame(8'h12, 1'b1, ^8'h12);
    idle(8);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    idle(8);
    send_frame(8'h07, 1'b1, 1'b0);
    idle(8);
`endif

    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: 8N1 serial frames on i_rx in, parallel bytes out.
- Peer of the uart_tx transmitter; shares the CLKS_PER_BIT bit-timing convention, so one parameter value serves both ends of a link.
- Samples each bit at mid-bit and rejects glitch start bits.
- Reports a framing error and waits out line-break conditions.

Parameters:
- CLKS_PER_BIT, 16: i_clk cycles per bit. Legal range 4..16383; the 14-bit counter limits the maximum.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_rx  in  1  serial line, asynchronous to i_clk, idle high
- o_rx_byte  out  8  last received byte, LSB = first data bit
- o_rx_byte_rdy  out  1  one-cycle pulse: o_rx_byte valid, frame good
- o_rx_frame_err  out  1  one-cycle pulse: stop bit sampled low
- o_rx_parity_err  out  1  one-cycle pulse: parity mismatch; constant 0 without UART_RX_PARITY_EN
- o_rx_busy  out  1  high in every state except IDLE

Behaviour:
- Reset: while i_rst_n = 0, all state clears asynchronously.
  - Outputs: o_rx_byte = 8'h00; o_rx_byte_rdy, o_rx_frame_err, o_rx_parity_err, o_rx_busy = 0.
  - Synchronizer flops reset to 1. FSM goes to IDLE; counter and bit index go to 0.
  - Reset mid-frame abandons the frame with no pulse. After release, the receiver waits for a new start bit.
- Input synchronizer: i_rx passes through 2 flops to give rx_s. All decisions use rx_s, so there is 2 cycles of input latency.
- HALF = (CLKS_PER_BIT-1)>>1 (integer). Counter: 14 bits, zeroed on every state change.
- FSM states and transitions:
  - IDLE: count = 0, idx = 0. If rx_s = 0, go to START.
  - START: count up to HALF, then sample rx_s.
    - rx_s = 0: go to DATA with count = 0.
    - rx_s = 1: glitch; return to IDLE with no output activity.
  - DATA: count up to CLKS_PER_BIT-1, then sample rx_s into shift bit [idx] and zero the count.
    - idx < 7: increment idx.
    - idx = 7: go to PARITY (macro defined) or STOP.
  - PARITY: one bit time, then sample the parity bit.
  - STOP: one bit time, then sample rx_s.
    - rx_s = 1: load o_rx_byte and pulse o_rx_byte_rdy, both in the cycle after the sample; go to DONE.
    - rx_s = 0: load o_rx_byte and pulse o_rx_frame_err; go to BREAK_WAIT.
  - DONE: one cycle, then IDLE. Pulses are exactly 1 cycle wide.
  - BREAK_WAIT: hold until rx_s = 1, then go to IDLE. No start detection while in this state.
- o_rx_byte changes only on a completed frame; it holds its value otherwise.
- o_rx_byte_rdy and o_rx_frame_err are never high together.
- Back-to-back frames: a start bit arriving in the DONE cycle is detected no more than 1 cycle late. Sampling stays within mid-bit tolerance.
- Latency: o_rx_byte_rdy rises 2 + HALF + 9*CLKS_PER_BIT + 2 cycles (±1) after the falling edge of i_rx (8N1).
- No input handshake and no buffering. The consumer must take o_rx_byte before the next frame completes; it is overwritten silently.

Optional Feature:
- Macro: UART_RX_PARITY_EN
- Defined:
  - Frame is 8E1; the PARITY state is active.
  - Even parity: a mismatch, when XOR(data) != the parity bit, pulses o_rx_parity_err in the same cycle as o_rx_byte_rdy.
  - A framing error takes precedence; parity is not reported on a framing error.
  - Latency grows by CLKS_PER_BIT.
- Undefined: the PARITY state is absent, the frame is 8N1, and o_rx_parity_err is tied to 0.

Test Plan:
- CLKS_PER_BIT=16, frame 0xA5 with stop=1 -> one 1-cycle o_rx_byte_rdy, o_rx_byte=0xA5, o_rx_frame_err never high, o_rx_busy low 1 cycle after DONE.
- Low glitch on i_rx of 5 cycles (< HALF=7) -> returns to IDLE; no rdy/err pulse; o_rx_byte unchanged.
- Frame 0x3C with stop bit held low, line low for 100 cycles, then high, then frame 0x81 -> o_rx_frame_err pulse with o_rx_byte=0x3C; no start detected during the low period; next rdy with 0x81.
- Two back-to-back frames 0x00 then 0xFF with zero idle gap -> two rdy pulses 160±1 cycles apart, bytes 0x00 and 0xFF.
- i_rst_n asserted during bit 4 of frame 0x55, released, then frame 0x12 -> all outputs 0 during reset, no pulse for the aborted frame, rdy with 0x12.
- With UART_RX_PARITY_EN: byte 0x07 with parity bit 1 -> rdy, no parity error; parity bit 0 -> rdy plus o_rx_parity_err in the same cycle.
